mem_stage_wb: RTL and testbench
===============================

Name: mem_stage_wb

Overview:
- Consumer end of the EX/MEM pipeline register in the MIPS pipeline.
- Takes the EX/MEM control and data fields and runs the data-memory access over a req/ack bus.
- Raises a pipeline stall while an access is outstanding.
- Registers the writeback-ready result into the MEM/WB pipeline register.

Parameters:
- ADDR_W, 32, data-memory byte address width.
- TIMEOUT_CYCLES, 16, REQ-state cycles before bus error; used only with MEM_TIMEOUT_EN.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- regwrite, memtoreg, memwrite  in  1 each  EX/MEM control fields.
- aluout  in  32  EX/MEM ALU result; also the memory address.
- writedata  in  32  EX/MEM store data.
- writereg  in  5  EX/MEM destination register.
- pcplus4  in  32  EX/MEM link address.
- jumplink  in  1  EX/MEM jal/jalr flag.
- syscall  in  1  EX/MEM syscall flag.
- stall  out  1  freeze request to PC, IF/ID, ID/EX and EX/MEM. Upstream holds the EX/MEM contents while it is high.
- dmem_req  out  1  memory request, registered.
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req is high.
- dmem_addr  out  ADDR_W  word-aligned address, {aluout[ADDR_W-1:2],2'b00}.
- dmem_wdata  out  32  store data.
- dmem_ack  in  1  one-cycle completion pulse from memory.
- dmem_rdata  in  32  load data; valid in the dmem_ack cycle.
- regwrite_w  out  1  MEM/WB register-write enable.
- writereg_w  out  5  MEM/WB destination register.
- result_w  out  32  MEM/WB writeback value.
- syscall_w  out  1  MEM/WB syscall flag.
- bus_err  out  1  one-cycle bus-error pulse; tied 0 when MEM_TIMEOUT_EN is off.

Behaviour:
- An access is pending when memtoreg | memwrite; memtoreg alone means a load.
- Reset: state IDLE. dmem_req, dmem_we, dmem_addr, dmem_wdata, regwrite_w, writereg_w, result_w, syscall_w, bus_err all 0. Reset asserted mid-access drops dmem_req immediately and abandons the transaction; a late ack is ignored.
- FSM has three states:
  - IDLE: no access → stall = 0; MEM/WB captures the instruction at this edge (one-cycle pass). Access → stall = 1; latch dmem_we/addr/wdata; go to REQ.
  - REQ: dmem_req = 1; addr/we/wdata held stable; stall = 1. On dmem_ack: capture dmem_rdata into an internal register, deassert dmem_req at the next edge, go to DONE.
  - DONE: stall = 0; MEM/WB captures at this edge; go to IDLE.
- Minimum memory-instruction latency is 3 cycles (ack in the first REQ cycle); each further REQ cycle adds 1.
- dmem_ack seen in IDLE or DONE is ignored.
- MEM/WB capture on a non-stall edge:
  - regwrite_w = regwrite; writereg_w = writereg; syscall_w = syscall.
  - result_w = pcplus4 if jumplink; else captured rdata if memtoreg; else aluout. Priority is in that order.
- MEM/WB on a stall edge: a bubble is inserted (regwrite_w = 0, syscall_w = 0). writereg_w and result_w are don't-care but held.
- Stores write no register unless regwrite is set; the block does not force this.
- Back-to-back accesses: DONE → IDLE → REQ. IDLE re-detects the held or new EX/MEM contents, so there is no lost or duplicated access.
- Alignment: aluout[1:0] is ignored; byte/half accesses are not supported.

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- Defined:
  - A counter runs in REQ and clears on REQ entry.
  - On reaching TIMEOUT_CYCLES without ack: drop dmem_req, go to DONE, use rdata = 0.
  - The retiring instruction gets regwrite_w forced 0, and bus_err pulses 1 for that one MEM/WB cycle.
  - An ack arriving in the same cycle as the timeout wins (normal completion, no error).
- Undefined: no counter; REQ waits indefinitely; bus_err = 0 constant.

Test Plan:
- ALU op: regwrite=1, writereg=5, aluout=0x1234 → next edge regwrite_w=1, writereg_w=5, result_w=0x1234; stall never asserted.
- Load, ack after 2 REQ cycles with rdata=0xDEADBEEF, aluout=0x103 → dmem_addr=0x100, dmem_we=0, stall high for 3 cycles with bubbles, then result_w=0xDEADBEEF, regwrite_w=1.
- Store, aluout=0x40, writedata=0xA5A5A5A5, ack in first REQ cycle → dmem_we=1, dmem_wdata=0xA5A5A5A5, total latency 3 cycles, exactly one dmem_req pulse train.
- jal, jumplink=1, pcplus4=0x00400008, writereg=31 → result_w=0x00400008, writereg_w=31.
- rst_n low during REQ → dmem_req=0 and all MEM/WB outputs 0 asynchronously; after release, IDLE; a stray ack produces no writeback.
- With MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, load never acked → dmem_req high 4 cycles, then bus_err=1 for 1 cycle, regwrite_w=0, stall released.

Source files
------------

// File: rtl/mem_stage_wb.sv
// mem_stage_wb: MEM stage of the MIPS pipeline. Consumes the EX/MEM fields,
// runs the data-memory access over a req/ack bus, stalls the front of the
// pipeline while an access is outstanding, and registers the MEM/WB fields.
// Optional feature: define MEM_TIMEOUT_EN to abort a REQ that waits
// TIMEOUT_CYCLES cycles without an ack. The access then retires with a bus
// error and no register write.
module mem_stage_wb #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              regwrite,
  input  logic              memtoreg,
  input  logic              memwrite,
  input  logic [31:0]       aluout,
  input  logic [31:0]       writedata,
  input  logic [4:0]        writereg,
  input  logic [31:0]       pcplus4,
  input  logic              jumplink,
  input  logic              syscall,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic              regwrite_w,
  output logic [4:0]        writereg_w,
  output logic [31:0]       result_w,
  output logic              syscall_w,
  output logic              bus_err
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  // A zero timeout would abort every access before the bus could answer.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_t              state_q, state_d;
  logic                dmem_req_q, dmem_req_d;
  logic                dmem_we_q, dmem_we_d;
  logic [ADDR_W-1:0]   dmem_addr_q, dmem_addr_d;
  logic [31:0]         dmem_wdata_q, dmem_wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                regwrite_w_q, regwrite_w_d;
  logic [4:0]          writereg_w_q, writereg_w_d;
  logic [31:0]         result_w_q, result_w_d;
  logic                syscall_w_q, syscall_w_d;
  logic                access;
  logic                capture;
  logic                err_now;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                bus_err_q, bus_err_d;
  assign err_now = err_q;
  assign bus_err = bus_err_q;
`else
  assign err_now = 1'b0;
  assign bus_err = 1'b0;
`endif

  assign access = memtoreg | memwrite;

  // Next-state logic: access sequencing, stall request and MEM/WB capture.
  always_comb begin
    state_d      = state_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    rdata_d      = rdata_q;
    stall        = 1'b0;
    capture      = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d        = '0;
    err_d        = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (access) begin
          stall        = 1'b1;
          dmem_req_d   = 1'b1;
          dmem_we_d    = memwrite;
          dmem_addr_d  = {aluout[ADDR_W-1:2], 2'b00};
          dmem_wdata_d = writedata;
          state_d      = REQ;
        end else begin
          capture = 1'b1;
        end
      end
      REQ: begin
        stall = 1'b1;
        if (dmem_ack) begin
          rdata_d    = dmem_rdata;
          dmem_req_d = 1'b0;
          state_d    = DONE;
        end
`ifdef MEM_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          rdata_d    = '0;
          dmem_req_d = 1'b0;
          err_d      = 1'b1;
          state_d    = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      DONE: begin
        capture = 1'b1;
        state_d = IDLE;
`ifdef MEM_TIMEOUT_EN
        err_d   = 1'b0;
`endif
      end
      default: state_d = IDLE;
    endcase

    // MEM/WB: capture on non-stall edges, bubble otherwise.
    writereg_w_d = writereg_w_q;
    result_w_d   = result_w_q;
    regwrite_w_d = 1'b0;
    syscall_w_d  = 1'b0;
`ifdef MEM_TIMEOUT_EN
    bus_err_d    = 1'b0;
`endif
    if (capture) begin
      regwrite_w_d = regwrite & ~err_now;
      writereg_w_d = writereg;
      syscall_w_d  = syscall;
      if (jumplink)      result_w_d = pcplus4;
      else if (memtoreg) result_w_d = rdata_q;
      else               result_w_d = aluout;
`ifdef MEM_TIMEOUT_EN
      bus_err_d    = err_now;
`endif
    end
  end

  // State, bus and MEM/WB registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      rdata_q      <= '0;
      regwrite_w_q <= 1'b0;
      writereg_w_q <= '0;
      result_w_q   <= '0;
      syscall_w_q  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q        <= '0;
      err_q        <= 1'b0;
      bus_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      rdata_q      <= rdata_d;
      regwrite_w_q <= regwrite_w_d;
      writereg_w_q <= writereg_w_d;
      result_w_q   <= result_w_d;
      syscall_w_q  <= syscall_w_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      bus_err_q    <= bus_err_d;
`endif
    end
  end

  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign regwrite_w = regwrite_w_q;
  assign writereg_w = writereg_w_q;
  assign result_w   = result_w_q;
  assign syscall_w  = syscall_w_q;

endmodule

// File: tb/tb_mem_stage_wb.sv
// tb_mem_stage_wb: randomized bench for mem_stage_wb. Each instruction is
// presented, a memory responder acks on a chosen REQ cycle, and the retired
// MEM/WB fields, latency and bus behaviour are compared with a transaction-level
// model of the stage.
module tb_mem_stage_wb;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        regwrite = 1'b0, memtoreg = 1'b0, memwrite = 1'b0;
  logic [31:0] aluout = '0, writedata = '0, pcplus4 = '0;
  logic [4:0]  writereg = '0;
  logic        jumplink = 1'b0, syscall = 1'b0;
  logic        stall, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        regwrite_w, syscall_w, bus_err;
  logic [4:0]  writereg_w;
  logic [31:0] result_w;

  int checks = 0;
  int errors = 0;

  mem_stage_wb #(.ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .regwrite(regwrite), .memtoreg(memtoreg), .memwrite(memwrite),
    .aluout(aluout), .writedata(writedata), .writereg(writereg),
    .pcplus4(pcplus4), .jumplink(jumplink), .syscall(syscall),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .regwrite_w(regwrite_w), .writereg_w(writereg_w), .result_w(result_w),
    .syscall_w(syscall_w), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present one instruction (caller is at a negedge) and follow it to retirement.
  // ack_k: the REQ cycle (1-based) in which memory acks.
  task automatic run_instr(input logic i_rw, input logic i_mtr, input logic i_mw,
                           input logic i_jl, input logic i_sc, input logic [4:0] i_wr,
                           input logic [31:0] i_alu, input logic [31:0] i_wd,
                           input logic [31:0] i_pc4, input logic [31:0] i_rd,
                           input int ack_k);
    logic        acc, to, done;
    int          exp_req, nreq, lat;
    logic [31:0] exp_res;
    acc = i_mtr | i_mw;
    to  = 1'b0;
`ifdef MEM_TIMEOUT_EN
    to = acc && (ack_k > TO);
`endif
    exp_req = !acc ? 0 : (to ? TO : ack_k);
    if (i_jl)       exp_res = i_pc4;
    else if (i_mtr) exp_res = to ? 32'h0 : i_rd;
    else            exp_res = i_alu;

    regwrite = i_rw; memtoreg = i_mtr; memwrite = i_mw; jumplink = i_jl;
    syscall = i_sc; writereg = i_wr; aluout = i_alu; writedata = i_wd;
    pcplus4 = i_pc4; dmem_ack = 1'b0;

    nreq = 0; lat = 0; done = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      #1;
      lat++;
      if (dmem_req) begin
        nreq++;
        check_val("addr", dmem_addr, {i_alu[31:2], 2'b00});
        check_val("we", 32'(dmem_we), 32'(i_mw));
        if (i_mw) check_val("wdata", dmem_wdata, i_wd);
        if (nreq == ack_k) begin
          dmem_ack = 1'b1;
          dmem_rdata = i_rd;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        // stray ack outside REQ must be ignored
        dmem_ack = 1'b1;
        dmem_rdata = $urandom;
      end
      if (!stall) done = 1'b1;
      @(posedge clk);
      #1;
      if (!done) begin
        check_val("bubble_rw", 32'(regwrite_w), 32'h0);
        check_val("bubble_sc", 32'(syscall_w), 32'h0);
      end
      @(negedge clk);
      dmem_ack = 1'b0;
    end
    check_val("stall_bound", 32'(done), 32'h1);
    check_val("latency", lat, acc ? exp_req + 2 : 1);
    check_val("req_cycles", nreq, exp_req);
    check_val("regwrite_w", 32'(regwrite_w), 32'(i_rw & ~to));
    check_val("writereg_w", 32'(writereg_w), 32'(i_wr));
    check_val("syscall_w", 32'(syscall_w), 32'(i_sc));
    check_val("result_w", result_w, exp_res);
    check_val("bus_err", 32'(bus_err), 32'(to));
    check_val("req_idle", 32'(dmem_req), 32'h0);
  endtask

  initial begin
    int kind, ack_max;
    ack_max = 6;

    // Reset state
    repeat (2) @(negedge clk);
    check_val("rst_req", 32'(dmem_req), 32'h0);
    check_val("rst_we", 32'(dmem_we), 32'h0);
    check_val("rst_addr", dmem_addr, 32'h0);
    check_val("rst_wdata", dmem_wdata, 32'h0);
    check_val("rst_rw", 32'(regwrite_w), 32'h0);
    check_val("rst_wr", 32'(writereg_w), 32'h0);
    check_val("rst_res", result_w, 32'h0);
    check_val("rst_sc", 32'(syscall_w), 32'h0);
    check_val("rst_berr", 32'(bus_err), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    run_instr(1, 0, 0, 0, 0, 5'd5, 32'h1234, 32'h0, 32'h0, 32'h0, 1);               // ALU op
    run_instr(1, 1, 0, 0, 0, 5'd8, 32'h103, 32'h0, 32'h0, 32'hDEADBEEF, 2);          // load
    run_instr(0, 0, 1, 0, 0, 5'd0, 32'h40, 32'hA5A5A5A5, 32'h0, 32'h0, 1);           // store
    run_instr(1, 0, 0, 1, 0, 5'd31, 32'h77, 32'h0, 32'h00400008, 32'h0, 1);          // jal
    run_instr(0, 0, 0, 0, 1, 5'd2, 32'h9, 32'h0, 32'h0, 32'h0, 1);                   // syscall
    run_instr(1, 1, 0, 1, 0, 5'd31, 32'h200, 32'h0, 32'h00400010, 32'h12345678, 1);  // jumplink beats load
    run_instr(1, 1, 0, 0, 0, 5'd9, 32'h204, 32'h0, 32'h0, 32'hCAFEF00D, 1);          // back-to-back load
`ifdef MEM_TIMEOUT_EN
    run_instr(1, 1, 0, 0, 0, 5'd10, 32'h300, 32'h0, 32'h0, 32'h55AA55AA, 1000);      // never acked
    run_instr(1, 0, 0, 0, 0, 5'd11, 32'h42, 32'h0, 32'h0, 32'h0, 1);                 // bus_err gone
`endif

    // Reset in the middle of a REQ
    regwrite = 1'b1; memtoreg = 1'b1; memwrite = 1'b0; jumplink = 1'b0;
    aluout = 32'h500; writereg = 5'd12; dmem_ack = 1'b0;
    @(posedge clk);
    #1;
    check_val("mid_req", 32'(dmem_req), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_req", 32'(dmem_req), 32'h0);
    check_val("arst_rw", 32'(regwrite_w), 32'h0);
    check_val("arst_wr", 32'(writereg_w), 32'h0);
    check_val("arst_res", result_w, 32'h0);
    check_val("arst_sc", 32'(syscall_w), 32'h0);
    regwrite = 1'b0; memtoreg = 1'b0; writereg = 5'd0; aluout = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    dmem_ack = 1'b1;
    dmem_rdata = 32'hBAD0BAD0;
    @(posedge clk);
    #1;
    check_val("late_ack_rw", 32'(regwrite_w), 32'h0);
    check_val("late_ack_req", 32'(dmem_req), 32'h0);
    @(negedge clk);
    dmem_ack = 1'b0;
    #1;
    check_val("late_ack_stall", 32'(stall), 32'h0);
    @(negedge clk);

    // Randomized instruction stream
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 4);
      case (kind)
        0: run_instr(1'($urandom), 0, 0, 0, 1'($urandom_range(0, 7) == 0), 5'($urandom),
                     $urandom, $urandom, $urandom, $urandom, 1);
        1: run_instr(1'($urandom), 1, 0, 0, 0, 5'($urandom), $urandom, $urandom,
                     $urandom, $urandom, $urandom_range(1, ack_max));
        2: run_instr(1'($urandom), 0, 1, 0, 0, 5'($urandom), $urandom, $urandom,
                     $urandom, $urandom, $urandom_range(1, ack_max));
        3: run_instr(1'($urandom), 1'($urandom), 0, 1, 0, 5'($urandom), $urandom, $urandom,
                     $urandom, $urandom, $urandom_range(1, ack_max));
        default: run_instr(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                           1'($urandom), 5'($urandom), $urandom, $urandom, $urandom,
                           $urandom, $urandom_range(1, ack_max));
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
